// File: rtl/mdu_e.sv
// E-stage multiply/divide unit for the MIPS pipeline. It owns HI/LO and reports busy to the hazard unit.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles; mthi/mtlo take one cycle. Starts are ignored while busy and blocked by Req.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUType,
  input  logic [31:0] A,
  input  logic [31:0] rt_data,
  input  logic [31:0] ext_imm,
  input  logic        BSel,
  input  logic        Req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   hi_p_q, lo_p_q;
  logic          wr_p_q;

  logic [31:0]   b_op;
  logic [63:0]   a_ext, b_ext, prod;
  logic          div_signed, a_neg, b_neg, b_zero;
  logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  logic          long_op;
  logic [31:0]   hi_d, lo_d;
  logic          wr_d;
  logic [CW-1:0] cnt_d;
  logic          accept;

  assign b_op = BSel ? ext_imm : rt_data;

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned product the signed result.
  assign a_ext = (MDUType == OP_MULT) ? {{32{A[31]}}, A}       : {32'h0, A};
  assign b_ext = (MDUType == OP_MULT) ? {{32{b_op[31]}}, b_op} : {32'h0, b_op};
  assign prod  = a_ext * b_ext;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign div_signed = (MDUType == OP_DIV);
  assign a_neg      = div_signed & A[31];
  assign b_neg      = div_signed & b_op[31];
  assign a_mag      = a_neg ? (~A + 32'd1) : A;
  assign b_mag      = b_neg ? (~b_op + 32'd1) : b_op;
  assign b_zero     = (b_op == 32'h0);
  assign b_safe     = b_zero ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    long_op = 1'b0;
    hi_d    = hi_p_q;
    lo_d    = lo_p_q;
    wr_d    = wr_p_q;
    cnt_d   = cnt_q;
    case (MDUType)
      OP_MULT, OP_MULTU: begin
        long_op = 1'b1;
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        wr_d    = 1'b1;
        cnt_d   = CW'(MULT_CYCLES);
      end
      OP_DIV, OP_DIVU: begin
        long_op = 1'b1;
        hi_d    = rem;
        lo_d    = quot;
        wr_d    = ~b_zero;
        cnt_d   = CW'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  assign accept = start & ~Req & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      hi_p_q  <= 32'h0;
      lo_p_q  <= 32'h0;
      wr_p_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (long_op) begin
              hi_p_q  <= hi_d;
              lo_p_q  <= lo_d;
              wr_p_q  <= wr_d;
              cnt_q   <= cnt_d;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else if (MDUType == OP_MTHI) begin
              hi_q <= A;
            end else if (MDUType == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (wr_p_q) begin
              hi_q <= hi_p_q;
              lo_q <= lo_p_q;
            end
            wr_p_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Scoreboard bench for mdu_e: the driver predicts completions into a queue, and a monitor checks them when busy falls.
module tb_mdu_e;
  logic        clk = 1'b0;
  logic        reset, start, BSel, Req;
  logic [3:0]  MDUType;
  logic [31:0] A, rt_data, ext_imm;
  logic        busy;
  logic [31:0] HI, LO;

  always #5 clk = ~clk;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUType(MDUType), .A(A),
    .rt_data(rt_data), .ext_imm(ext_imm), .BSel(BSel), .Req(Req),
    .busy(busy), .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          ncyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic applied to the committed HI/LO.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output int ncyc);
    longint          sa, sb, p, q, r;
    longint unsigned up;
    hi = m_hi;
    lo = m_lo;
    ncyc = 0;
    case (op)
      4'd1: begin
        sa = $signed(a); sb = $signed(b); p = sa * sb;
        hi = p[63:32]; lo = p[31:0]; ncyc = 5;
      end
      4'd2: begin
        up = {32'h0, a} * {32'h0, b};
        hi = up[63:32]; lo = up[31:0]; ncyc = 5;
      end
      4'd3: begin
        ncyc = 10;
        if (b != 32'h0) begin
          sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      4'd4: begin
        ncyc = 10;
        if (b != 32'h0) begin
          lo = a / b; hi = a % b;
        end
      end
      4'd5: hi = a;
      4'd6: lo = a;
      default: ;
    endcase
  endfunction

  // Called at a negedge; the start is sampled on the following posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input logic [31:0] imm, input logic bsel, input logic req);
    logic [31:0] b, eh, el;
    int          nc;
    exp_t        e;
    b = bsel ? imm : rt;
    ref_op(op, a, b, eh, el, nc);
    start = 1'b1; MDUType = op; A = a; rt_data = rt; ext_imm = imm; BSel = bsel; Req = req;
    if (!req) begin
      if (nc != 0) begin
        e.hi = eh; e.lo = el; e.ncyc = nc;
        exp_q.push_back(e);
      end
      m_hi = eh;
      m_lo = el;
    end
    #1 chk("no_comb_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0; Req = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", busy, 1'b0);
    chk("idle_hi", HI, m_hi);
    chk("idle_lo", LO, m_lo);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_hi"}, HI, m_hi);
    chk({nm, "_lo"}, LO, m_lo);
  endtask

  // Monitor: counts busy cycles, checks HI/LO hold steady while busy, and pops on each completion.
  logic        mon_prev = 1'b0;
  int          mon_cnt = 0;
  logic [31:0] hold_hi, hold_lo;
  exp_t        mon_e;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mon_prev = 1'b0;
      mon_cnt  = 0;
    end else begin
      if (busy) begin
        if (!mon_prev) begin
          hold_hi = HI;
          hold_lo = LO;
        end else begin
          chk("hold_hi", HI, hold_hi);
          chk("hold_lo", LO, hold_lo);
        end
        mon_cnt++;
      end else if (mon_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_done: completion seen with no expected op");
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_hi", HI, mon_e.hi);
          chk("done_lo", LO, mon_e.lo);
          chk("busy_cycles", mon_cnt, mon_e.ncyc);
        end
        mon_cnt = 0;
      end
      mon_prev = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rrt, rimm;
    logic        rb, rq;
    reset = 1'b0; start = 1'b0; MDUType = 4'h0; A = 32'h0; rt_data = 32'h0;
    ext_imm = 32'h0; BSel = 1'b0; Req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a mult
    issue(4'd1, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0);
    chk("busy_rise", busy, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_hi", HI, 32'h0);
    chk("async_lo", LO, 32'h0);
    exp_q.delete();
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk_quiet("post_rst");
    end

    // Directed arithmetic cases
    issue(4'd1, 32'hFFFFFFFE, 32'h3, 32'h0, 1'b0, 1'b0); wait_idle();
    chk("mult_hi", HI, 32'hFFFFFFFF); chk("mult_lo", LO, 32'hFFFFFFFA);
    issue(4'd2, 32'hFFFFFFFE, 32'h3, 32'h0, 1'b0, 1'b0); wait_idle();
    chk("multu_hi", HI, 32'h2); chk("multu_lo", LO, 32'hFFFFFFFA);
    issue(4'd3, 32'hFFFFFFF9, 32'h1234, 32'h2, 1'b1, 1'b0); wait_idle();
    chk("divimm_lo", LO, 32'hFFFFFFFD); chk("divimm_hi", HI, 32'hFFFFFFFF);
    issue(4'd4, 32'd7, 32'd2, 32'h0, 1'b0, 1'b0); wait_idle();
    chk("divu_lo", LO, 32'd3); chk("divu_hi", HI, 32'd1);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0); wait_idle();
    chk("ovf_lo", LO, 32'h80000000); chk("ovf_hi", HI, 32'h0);

    // Divide by zero leaves a preset HI/LO untouched
    issue(4'd5, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(4'd6, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(4'd3, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0); wait_idle();
    chk("div0_hi", HI, 32'h11); chk("div0_lo", LO, 32'h22);

    // mthi / mtlo and Req blocking
    issue(4'd5, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("mthi_hi", HI, 32'hDEADBEEF); chk("mthi_busy", busy, 1'b0);
    @(negedge clk); chk("mthi_busy2", busy, 1'b0);
    issue(4'd6, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("mtlo_req_lo", LO, 32'h22);
    issue(4'd1, 32'd9, 32'd9, 32'h0, 1'b0, 1'b1);
    chk_quiet("mult_req");
    @(negedge clk); chk_quiet("mult_req2");

    // start during RUN is ignored
    issue(4'd1, 32'd7, 32'd9, 32'h0, 1'b0, 1'b0);
    start = 1'b1; MDUType = 4'd3; A = 32'd100; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("ignore_lo", LO, 32'd63); chk("ignore_hi", HI, 32'd0);

    // Req during RUN does not abort
    issue(4'd3, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0);
    @(negedge clk); Req = 1'b1;
    repeat (3) @(negedge clk);
    Req = 1'b0;
    wait_idle();
    chk("req_run_lo", LO, 32'd14); chk("req_run_hi", HI, 32'd2);

    // Back-to-back: next start in the first idle cycle
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0); wait_idle();
    issue(4'd4, 32'd1000, 32'd0, 32'd33, 1'b1, 1'b0); wait_idle();
    chk("b2b_lo", LO, 32'd30); chk("b2b_hi", HI, 32'd10);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op   = 4'($urandom_range(0, 7));
      ra   = $urandom;
      rrt  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rimm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = {1'b1, 31'($urandom_range(0, 7))};
      rb   = 1'($urandom_range(0, 1));
      rq   = ($urandom_range(0, 7) == 0);
      issue(op, ra, rrt, rimm, rb, rq);
      if (!rq && op >= 4'd1 && op <= 4'd4) wait_idle();
      else chk_quiet("rand_short");
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
